// File: rtl/baud_nco_if.sv
// Bus bundle for baud_nco: run/config controls in, tick and status outputs back.
// The master drives controls and config; the slave (the NCO) returns ticks and status.
interface baud_nco_if #(
    parameter int ACC_W        = 24,
    parameter int OVS_MAX_LOG2 = 4
);
    logic                    en;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [ACC_W-1:0]        cfg_inc;
    logic [2:0]              cfg_ovs_log2;
    logic                    resync;
    logic                    tick_os;
    logic                    mid_tick;
    logic                    baud_tick;
    logic [OVS_MAX_LOG2-1:0] os_phase;
    logic [ACC_W-1:0]        active_inc;

    modport master (
        output en, cfg_valid, cfg_inc, cfg_ovs_log2, resync,
        input  cfg_ready, tick_os, mid_tick, baud_tick, os_phase, active_inc
    );

    modport slave (
        input  en, cfg_valid, cfg_inc, cfg_ovs_log2, resync,
        output cfg_ready, tick_os, mid_tick, baud_tick, os_phase, active_inc
    );
endinterface

// File: rtl/baud_nco.sv
// Fractional baud NCO with 4/8/16x oversampling and bit-boundary reprogramming.
// Optional feature macro: BAUD_NCO_RESYNC_EN enables the resync phase-realign input.
module baud_nco #(
    parameter int               ACC_W        = 24,
    parameter logic [ACC_W-1:0] RESET_INC    = ACC_W'(309237),
    parameter int               OVS_MAX_LOG2 = 4,
    parameter int               OVS_RST_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset,
    baud_nco_if.slave  bus
);

    typedef enum logic {
        SLOT_FREE,
        SLOT_PENDING
    } slotState_e;

    slotState_e              slot_q, slot_d;
    logic                    cfgReady_q, cfgReady_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [ACC_W-1:0]        activeInc_q, activeInc_d;
    logic [ACC_W-1:0]        pendInc_q, pendInc_d;
    logic [2:0]              ovs_q, ovs_d;
    logic [2:0]              pendOvs_q, pendOvs_d;
    logic [OVS_MAX_LOG2-1:0] osPhase_q, osPhase_d;
    logic                    tickOs_q, tickOs_d;
    logic                    midTick_q, midTick_d;
    logic                    baudTick_q, baudTick_d;

    logic [ACC_W:0]          sum;
    logic                    carry;
    logic                    lastPhase;
    logic                    applyCfg;
    logic                    resyncHit;
    logic [2:0]              ovsClamped;
    logic [OVS_MAX_LOG2:0]   ovsOneHot;
    logic [OVS_MAX_LOG2-1:0] lastIdx;
    logic [OVS_MAX_LOG2-1:0] midIdx;

`ifdef BAUD_NCO_RESYNC_EN
    assign resyncHit = bus.resync;
`else
    logic unusedResync;
    assign unusedResync = bus.resync;
    assign resyncHit    = 1'b0;
`endif

    always_comb begin
        sum        = {1'b0, acc_q} + {1'b0, activeInc_q};
        carry      = bus.en && sum[ACC_W];
        ovsOneHot  = (OVS_MAX_LOG2+1)'(1) << ovs_q;
        lastIdx    = OVS_MAX_LOG2'(ovsOneHot - 1'b1);
        midIdx     = OVS_MAX_LOG2'((ovsOneHot >> 1) - 1'b1);
        // >= keeps the phase wrapping if a smaller ratio lands mid-bit while disabled
        lastPhase  = (osPhase_q >= lastIdx);
        applyCfg   = (slot_q == SLOT_PENDING) && !resyncHit &&
                     (!bus.en || (carry && lastPhase));

        if (bus.cfg_ovs_log2 < 3'd2)
            ovsClamped = 3'd2;
        else if (bus.cfg_ovs_log2 > 3'(OVS_MAX_LOG2))
            ovsClamped = 3'(OVS_MAX_LOG2);
        else
            ovsClamped = bus.cfg_ovs_log2;

        acc_d       = acc_q;
        osPhase_d   = osPhase_q;
        tickOs_d    = 1'b0;
        midTick_d   = 1'b0;
        baudTick_d  = 1'b0;
        slot_d      = slot_q;
        cfgReady_d  = cfgReady_q;
        activeInc_d = activeInc_q;
        ovs_d       = ovs_q;
        pendInc_d   = pendInc_q;
        pendOvs_d   = pendOvs_q;

        if (bus.en)
            acc_d = sum[ACC_W-1:0];

        if (carry) begin
            tickOs_d   = 1'b1;
            baudTick_d = lastPhase;
            midTick_d  = (osPhase_q == midIdx);
            osPhase_d  = lastPhase ? '0 : osPhase_q + 1'b1;
        end

        // The accumulator is kept across a config change so the phase never jumps
        if (applyCfg) begin
            activeInc_d = pendInc_q;
            ovs_d       = pendOvs_q;
            slot_d      = SLOT_FREE;
            cfgReady_d  = 1'b1;
        end else if (bus.cfg_valid && cfgReady_q) begin
            pendInc_d   = bus.cfg_inc;
            pendOvs_d   = ovsClamped;
            slot_d      = SLOT_PENDING;
            cfgReady_d  = 1'b0;
        end

        if (resyncHit) begin
            acc_d      = '0;
            osPhase_d  = '0;
            tickOs_d   = 1'b0;
            midTick_d  = 1'b0;
            baudTick_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q      <= SLOT_FREE;
            cfgReady_q  <= 1'b1;
            acc_q       <= '0;
            activeInc_q <= RESET_INC;
            pendInc_q   <= '0;
            ovs_q       <= 3'(OVS_RST_LOG2);
            pendOvs_q   <= 3'(OVS_RST_LOG2);
            osPhase_q   <= '0;
            tickOs_q    <= 1'b0;
            midTick_q   <= 1'b0;
            baudTick_q  <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            cfgReady_q  <= cfgReady_d;
            acc_q       <= acc_d;
            activeInc_q <= activeInc_d;
            pendInc_q   <= pendInc_d;
            ovs_q       <= ovs_d;
            pendOvs_q   <= pendOvs_d;
            osPhase_q   <= osPhase_d;
            tickOs_q    <= tickOs_d;
            midTick_q   <= midTick_d;
            baudTick_q  <= baudTick_d;
        end
    end

    assign bus.cfg_ready  = cfgReady_q;
    assign bus.tick_os    = tickOs_q;
    assign bus.mid_tick   = midTick_q;
    assign bus.baud_tick  = baudTick_q;
    assign bus.os_phase   = osPhase_q;
    assign bus.active_inc = activeInc_q;

endmodule

// File: tb/tb_baud_nco.sv
// Directed self-checking bench for baud_nco: tick spacing, reprogramming, clamp, enable, rate.
// Resync checks are compiled in only when BAUD_NCO_RESYNC_EN is defined.
module tb_baud_nco;

   localparam int               ACC_W        = 24;
   localparam int               OVS_MAX_LOG2 = 4;
   localparam logic [ACC_W-1:0] RESET_INC    = 24'd309237;
   localparam logic [ACC_W-1:0] INC_2P20     = 24'h10_0000;
   localparam logic [ACC_W-1:0] INC_2P21     = 24'h20_0000;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   int   osCnt    = 0;
   int   midCnt   = 0;
   int   baudCnt  = 0;

   baud_nco_if #(.ACC_W(ACC_W), .OVS_MAX_LOG2(OVS_MAX_LOG2)) bus ();

   baud_nco #(
      .ACC_W(ACC_W),
      .RESET_INC(RESET_INC),
      .OVS_MAX_LOG2(OVS_MAX_LOG2),
      .OVS_RST_LOG2(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Running tick totals sampled on the falling edge, read as before/after snapshots
   always @(negedge clk) begin
      if (bus.tick_os)   osCnt   = osCnt + 1;
      if (bus.mid_tick)  midCnt  = midCnt + 1;
      if (bus.baud_tick) baudCnt = baudCnt + 1;
   end

   task automatic checkOutput(input string tag, input longint actual, input longint expected);
      checks = checks + 1;
      if (actual !== expected) begin
         failures = failures + 1;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   // Offers one config word for a single cycle; it must be taken on that edge
   task automatic applyStimulus(input string tag, input logic [ACC_W-1:0] inc, input logic [2:0] ovs);
      bus.cfg_valid    = 1'b1;
      bus.cfg_inc      = inc;
      bus.cfg_ovs_log2 = ovs;
      @(negedge clk);
      checkOutput({tag, "_ready_low"}, bus.cfg_ready, 0);
      bus.cfg_valid    = 1'b0;
   endtask

   task automatic programIdle(input string tag, input logic [ACC_W-1:0] inc, input logic [2:0] ovs);
      applyStimulus(tag, inc, ovs);
      @(negedge clk);
      checkOutput({tag, "_ready_back"}, bus.cfg_ready, 1);
      checkOutput({tag, "_active_inc"}, bus.active_inc, inc);
   endtask

   task automatic doReset();
      bus.en           = 1'b0;
      bus.cfg_valid    = 1'b0;
      bus.cfg_inc      = '0;
      bus.cfg_ovs_log2 = 3'd4;
      bus.resync       = 1'b0;
      reset            = 1'b1;
      repeat (2) @(negedge clk);
      reset            = 1'b0;
   endtask

   // Counts falling edges until the selected tick shows; -1 when the budget runs out
   task automatic waitEvent(input int sel, input int maxCyc, output int k);
      bit seen;
      k    = 0;
      seen = 1'b0;
      while (!seen && k < maxCyc) begin
         @(negedge clk);
         k = k + 1;
         case (sel)
            0:       seen = bus.tick_os;
            1:       seen = bus.mid_tick;
            default: seen = bus.baud_tick;
         endcase
      end
      if (!seen) k = -1;
   endtask

   initial begin
      int k;
      int os0, mid0, baud0;

      doReset();
      checkOutput("rst_ready", bus.cfg_ready, 1);
      checkOutput("rst_tick_os", bus.tick_os, 0);
      checkOutput("rst_mid", bus.mid_tick, 0);
      checkOutput("rst_baud", bus.baud_tick, 0);
      checkOutput("rst_os_phase", bus.os_phase, 0);
      checkOutput("rst_active_inc", bus.active_inc, RESET_INC);

      // 16x at inc 2^20: carry every 16 clocks, mid at carry 8, boundary at carry 16
      programIdle("t1_cfg", INC_2P20, 3'd4);
      bus.en = 1'b1;
      waitEvent(0, 100, k);  checkOutput("t1_first_os", k, 16);
      waitEvent(0, 100, k);  checkOutput("t1_os_period", k, 16);
      waitEvent(1, 200, k);  checkOutput("t1_mid_at_128", k, 96);
      checkOutput("t1_phase_at_mid", bus.os_phase, 8);
      waitEvent(2, 300, k);  checkOutput("t1_baud_at_256", k, 128);
      checkOutput("t1_phase_at_baud", bus.os_phase, 0);
      checkOutput("t1_no_mid_at_baud", bus.mid_tick, 0);
      waitEvent(2, 300, k);  checkOutput("t1_baud_period", k, 256);

      // Mid-bit reprogramming to 2^21 waits for the boundary
      repeat (50) @(negedge clk);
      applyStimulus("t2", INC_2P21, 3'd4);
      repeat (100) @(negedge clk);
      checkOutput("t2_ready_held", bus.cfg_ready, 0);
      checkOutput("t2_old_inc", bus.active_inc, INC_2P20);
      waitEvent(2, 300, k);  checkOutput("t2_boundary", k, 105);
      checkOutput("t2_ready_on_apply", bus.cfg_ready, 1);
      checkOutput("t2_new_inc", bus.active_inc, INC_2P21);
      waitEvent(0, 50, k);   checkOutput("t2_os_first", k, 8);
      waitEvent(0, 50, k);   checkOutput("t2_os_period", k, 8);
      waitEvent(2, 300, k);  checkOutput("t2_baud_rest", k, 112);
      waitEvent(2, 300, k);  checkOutput("t2_baud_period", k, 128);

      // Oversampling clamp: 7 behaves as 16x, 0 behaves as 4x
      applyStimulus("t3a", INC_2P21, 3'd7);
      waitEvent(2, 300, k);  checkOutput("t3_apply_hi", k, 127);
      waitEvent(2, 300, k);  checkOutput("t3_clamp16_period", k, 128);
      applyStimulus("t3b", INC_2P21, 3'd0);
      waitEvent(2, 300, k);  checkOutput("t3_apply_lo", k, 127);
      waitEvent(1, 100, k);  checkOutput("t3_mid_4x", k, 16);
      checkOutput("t3_phase_at_mid", bus.os_phase, 2);
      waitEvent(2, 100, k);  checkOutput("t3_baud_4x", k, 16);
      #1 os0 = osCnt;
      waitEvent(2, 100, k);  checkOutput("t3_baud_period_4x", k, 32);
      #1 checkOutput("t3_os_per_bit", osCnt - os0, 4);

      // Enable low for 37 clocks one oversample into the bit, then resume
      repeat (12) @(negedge clk);
      #1 bus.en = 1'b0;
      os0 = osCnt; mid0 = midCnt; baud0 = baudCnt;
      repeat (37) @(negedge clk);
      #1 checkOutput("t5_no_ticks", (osCnt - os0) + (midCnt - mid0) + (baudCnt - baud0), 0);
      checkOutput("t5_phase_frozen", bus.os_phase, 1);
      bus.en = 1'b1;
      waitEvent(1, 50, k);   checkOutput("t5_resume_mid", k, 4);
      waitEvent(2, 50, k);   checkOutput("t5_resume_baud", k, 16);

      // Reset increment over 50000 clocks: 921 carries, 58 mids, 57 boundaries
      doReset();
      #1 os0 = osCnt; mid0 = midCnt; baud0 = baudCnt;
      bus.en = 1'b1;
      repeat (50000) @(negedge clk);
      #1 checkOutput("t4_os_count", osCnt - os0, 921);
      checkOutput("t4_mid_count", midCnt - mid0, 58);
      checkOutput("t4_baud_count", baudCnt - baud0, 57);

      // Zero increment never ticks, so a later offer stays pending until reset
      bus.en = 1'b0;
      programIdle("t4z_cfg", '0, 3'd4);
      bus.en = 1'b1;
      #1 os0 = osCnt; mid0 = midCnt; baud0 = baudCnt;
      repeat (1000) @(negedge clk);
      #1 checkOutput("t4z_no_ticks", (osCnt - os0) + (midCnt - mid0) + (baudCnt - baud0), 0);
      applyStimulus("t7", 24'd5, 3'd4);
      repeat (20) @(negedge clk);
      checkOutput("t7_still_pending", bus.active_inc, 0);
      checkOutput("t7_ready_low", bus.cfg_ready, 0);
      doReset();
      checkOutput("t7_reset_inc", bus.active_inc, RESET_INC);
      checkOutput("t7_reset_ready", bus.cfg_ready, 1);

`ifdef BAUD_NCO_RESYNC_EN
      // Resync on the carry edge wins, then the bit restarts from phase 0
      programIdle("t6_cfg", INC_2P20, 3'd4);
      bus.en = 1'b1;
      repeat (15) @(negedge clk);
      bus.resync = 1'b1;
      @(negedge clk);
      bus.resync = 1'b0;
      checkOutput("t6_no_tick", bus.tick_os, 0);
      checkOutput("t6_phase_zero", bus.os_phase, 0);
      #1 os0 = osCnt;
      waitEvent(1, 300, k);  checkOutput("t6_mid_delay", k, 128);
      #1 checkOutput("t6_os_before_mid", osCnt - os0, 8);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
